stopwatch_ctrl: RTL and testbench

- Stopwatch controller for the mm:ss display. It holds the seconds and minutes counters (0–59 each) and runs the start/pause/clear state machine.
- One shared sec/min-to-7-seg decoder instance (6-bit value in; tens/units 7-bit active-low patterns out) is time-multiplexed across four common-anode digits.
- Sits between the board buttons (already debounced and pulse-shaped) and the 4-digit display.

---
 rtl/stopwatch_pkg.sv | 11 +
 rtl/stopwatch_scan.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 152 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch block (state encoding, count limit, blank pattern).
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [5:0] MAX_SECMIN = 6'd59;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
endpackage

// File: rtl/stopwatch_scan.sv
// Digit scanner: scan counter, digit index, registered anode decode and tens/units segment select.
// Latency: anodes registered with digit_idx; seg_out combinational. No backpressure; free-running.
module stopwatch_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dec_seg0,
    input  logic [6:0] dec_seg1,
    output logic [1:0] digit_idx,
    output logic [3:0] an,
    output logic [6:0] seg_out
);
    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  SCAN_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        // Anode is derived from the next index so it always matches digit_idx.
        an_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1110;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
        end
    end

    assign digit_idx = idx_q;
    assign an        = an_q;
    assign seg_out   = idx_q[0] ? dec_seg1 : dec_seg0;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mm:ss controller: start/pause/clear FSM, 1 s prescaler, sec/min counters, display mux.
// Count updates one edge after tick; display paths combinational from digit_idx. Optional lap freeze: STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [5:0] dec_value,
    input  logic [6:0] dec_seg0,
    input  logic [6:0] dec_seg1,
    output logic [6:0] seg_out,
    output logic [3:0] an,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       running,
    output logic       rollover
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic          roll_q, roll_d;
    logic          tick;
    logic [1:0]    digit_idx;
    logic [5:0]    src_sec, src_min;

    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        roll_d  = 1'b0;
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            if (sec_q == MAX_SECMIN) begin
                sec_d = '0;
                if (min_q == MAX_SECMIN) begin
                    min_d  = '0;
                    roll_d = 1'b1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        // clear dominates everything, including a same-cycle start_stop or tick.
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
            roll_d  = 1'b0;
        end else if (start_stop) begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    presc_d = '0;
                end
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            roll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            roll_q  <= roll_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       freeze_q, freeze_d;
    logic [5:0] lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;

    always_comb begin
        freeze_d  = freeze_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        if (clear) begin
            freeze_d = 1'b0;
        end else if (lap) begin
            if (freeze_q) begin
                freeze_d = 1'b0;
            end else if (state_q == RUN) begin
                freeze_d  = 1'b1;
                lap_sec_d = sec_q;
                lap_min_d = min_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_q  <= 1'b0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
        end else begin
            freeze_q  <= freeze_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
        end
    end

    assign src_sec = freeze_q ? lap_sec_q : sec_q;
    assign src_min = freeze_q ? lap_min_q : min_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign src_sec    = sec_q;
    assign src_min    = min_q;
`endif

    stopwatch_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .dec_seg0  (dec_seg0),
        .dec_seg1  (dec_seg1),
        .digit_idx (digit_idx),
        .an        (an),
        .seg_out   (seg_out)
    );

    assign dec_value = (digit_idx < 2'd2) ? src_sec : src_min;
    assign sec       = sec_q;
    assign min       = min_q;
    assign running   = (state_q == RUN);
    assign rollover  = roll_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: elapsed-time reference model plus directed and random pulses.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst, start_stop, clear, lap;
    logic [5:0] dec_value, sec, min;
    logic [6:0] dec_seg0, dec_seg1, seg_out;
    logic [3:0] an;
    logic       running, rollover;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .dec_value  (dec_value),
        .dec_seg0   (dec_seg0),
        .dec_seg1   (dec_seg1),
        .seg_out    (seg_out),
        .an         (an),
        .sec        (sec),
        .min        (min),
        .running    (running),
        .rollover   (rollover)
    );

    // Active-low a..g, segment a in the MSB.
    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Shared decoder that sits beside the controller at the parent level.
    assign dec_seg0 = seg7(int'(dec_value) % 10);
    assign dec_seg1 = seg7(int'(dec_value) / 10);

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stopwatch time is simply RUN cycles elapsed since clear, divided down.
    int m_cycles = 0;
    bit m_run    = 0;
    bit m_frozen = 0;
    int m_lap_t  = 0;
    bit m_roll   = 0;
    int m_scan   = 0;

    function automatic int m_time();
        return (m_cycles / TICK_DIV) % 3600;
    endfunction

    always @(posedge clk) begin
        m_roll = 0;
        if (rst) begin
            m_cycles = 0;
            m_run    = 0;
            m_frozen = 0;
            m_scan   = 0;
        end else begin
            m_scan++;
            if (clear) begin
                m_cycles = 0;
                m_run    = 0;
                m_frozen = 0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (lap) begin
                    if (m_frozen) m_frozen = 0;
                    else if (m_run) begin
                        m_frozen = 1;
                        m_lap_t  = m_time();
                    end
                end
`endif
                if (m_run) begin
                    m_cycles++;
                    if (m_cycles % (TICK_DIV * 3600) == 0) m_roll = 1;
                end
                if (start_stop) m_run = !m_run;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int         t, shown, digit, dv;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        if (chk_en) begin
            t     = m_time();
            digit = (m_scan / SCAN_DIV) % 4;
            shown = m_frozen ? m_lap_t : t;
            dv    = (digit < 2) ? shown % 60 : shown / 60;
            e_an  = ~(4'b0001 << digit);
            e_seg = (digit % 2 == 1) ? seg7(dv / 10) : seg7(dv % 10);
            check("model_sec", sec, t % 60);
            check("model_min", min, t / 60);
            check("model_running", running, m_run);
            check("model_rollover", rollover, m_roll);
            check("model_an", an, e_an);
            check("model_dec_value", dec_value, dv);
            check("model_seg_out", seg_out, e_seg);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic wait_time(input int t, input int budget);
        int k = 0;
        while (m_time() != t && k < budget) begin
            cyc(1);
            k++;
        end
        if (m_time() != t) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_time: time %0d never reached, expected %0d", m_time(), t);
        end
    endtask

    initial begin
        logic [3:0] prev_an;
        int         changes, hits, rolls, k;
        logic [5:0] s0;
        bit         saw_5959;

        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        cyc(1);
        chk_en = 1;
        cyc(2);
        check("reset_sec", sec, 0);
        check("reset_an", an, 4'b1110);
        check("reset_running", running, 0);
        rst = 1'b0;

        // Idle scan: anodes step every SCAN_DIV cycles.
        prev_an = an;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (an !== prev_an) changes++;
            prev_an = an;
        end
        check("idle_sec", sec, 0);
        check("idle_min", min, 0);
        check("idle_running", running, 0);
        check("idle_an_changes", changes, 10);
        check("idle_an_final", an, 4'b1011);

        // First tick lands exactly TICK_DIV edges after the start edge.
        pulse_ss();
        cyc(3);
        check("first_tick_early", sec, 0);
        cyc(1);
        check("first_tick", sec, 1);
        cyc(236);
        check("one_min_min", min, 1);
        check("one_min_sec", sec, 0);
        check("one_min_running", running, 1);

        // Pause at 12:34 and inspect every digit.
        wait_time(754, 4000);
        pulse_ss();
        check("pause_running", running, 0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            case (an)
                4'b1110: begin check("digit0_seg", seg_out, 7'b1001100); check("digit0_val", dec_value, 34); hits++; end
                4'b1101: begin check("digit1_seg", seg_out, 7'b0000110); hits++; end
                4'b1011: begin check("digit2_seg", seg_out, 7'b0010010); check("digit2_val", dec_value, 12); hits++; end
                4'b0111: begin check("digit3_seg", seg_out, 7'b1001111); hits++; end
                default: ;
            endcase
        end
        check("digit_hits", hits, 8);

        // Pause with two prescaler counts banked; resume must keep them.
        pulse_ss();
        k = 0;
        while (m_cycles % TICK_DIV != 1 && k < 10) begin cyc(1); k++; end
        s0 = sec;
        pulse_ss();
        cyc(50);
        check("paused_sec_hold", sec, s0);
        pulse_ss();
        check("resume_sec_r0", sec, s0);
        cyc(1);
        check("resume_sec_r1", sec, s0);
        cyc(1);
        check("resume_sec_r2", sec, (s0 + 1) % 60);

        // Random pulse traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            start_stop = ($urandom_range(0, 29) == 0);
            clear      = ($urandom_range(0, 199) == 0);
            lap        = ($urandom_range(0, 19) == 0);
            cyc(1);
        end
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

        // Full wrap 59:59 -> 00:00.
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        pulse_ss();
        wait_time(3598, 16000);
        check("pre_wrap_min", min, 59);
        check("pre_wrap_sec", sec, 58);
        rolls = 0;
        saw_5959 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (rollover === 1'b1) rolls++;
            if (min == 59 && sec == 59) saw_5959 = 1;
        end
        check("wrap_rollover_count", rolls, 1);
        check("wrap_saw_5959", saw_5959, 1);
        check("wrap_min", min, 0);
        check("wrap_sec", sec, 0);
        cyc(1);
        check("wrap_rollover_drop", rollover, 0);

        // clear beats a same-cycle start_stop.
        cyc(5);
        clear = 1'b1; start_stop = 1'b1;
        cyc(1);
        clear = 1'b0; start_stop = 1'b0;
        check("clr_ss_running", running, 0);
        check("clr_ss_sec", sec, 0);
        cyc(10);
        check("clr_ss_idle_sec", sec, 0);
        check("clr_ss_idle_min", min, 0);

`ifdef STOPWATCH_LAP_EN
        pulse_ss();
        wait_time(5, 40);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        cyc(8);
        check("lap_live_sec", sec, 7);
        for (int i = 0; i < 8; i++) begin
            if (an == 4'b1110 || an == 4'b1101) check("lap_frozen_val", dec_value, 5);
            cyc(1);
        end
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (an == 4'b1110 || an == 4'b1101) check("lap_release_val", dec_value, sec);
            cyc(1);
        end
`endif

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
